// File: rtl/sign_mag_accum.sv
// Sign-magnitude accumulator: one operand per valid/ready transaction (add, sub, load, clear),
// compare-then-write pipeline with sticky overflow flag; saturating or wrapping per SAT.
module sign_mag_accum #(
  parameter int N   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] din,
  input  logic         ovf_clr,
  output logic [N-1:0] acc,
  output logic         out_valid,
  output logic         ovf
);

  localparam int M = N - 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CMP   = 2'b01,
    S_WRITE = 2'b10
  } state_t;

  // Only a same-sign sum can carry into bit M; a difference of ordered magnitudes cannot.
  function automatic logic [M-1:0] sat_mag(input logic [M:0] sum);
    if (sum[M]) begin
      return SAT ? {M{1'b1}} : sum[M-1:0];
    end
    return sum[M-1:0];
  endfunction

  // Any zero magnitude is forced to +0 so that -0 never reaches the accumulator.
  function automatic logic [N-1:0] norm(input logic sgn, input logic [M-1:0] mag);
    return (mag == '0) ? '0 : {sgn, mag};
  endfunction

  state_t         r_state;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [N-1:0]   r_acc;
  logic           r_ovf;

  logic [1:0]     r_op_p0;
  logic [N-1:0]   r_din_p0;
  logic [M-1:0]   r_big_p1;
  logic [M-1:0]   r_small_p1;
  logic           r_sign_p1;
  logic           r_same_p1;

  logic [M-1:0]   w_a_mag;
  logic [M-1:0]   w_b_mag;
  logic           w_b_sign;
  logic           w_a_ge;
  logic [M:0]     w_sum;
  logic [N-1:0]   w_acc_nxt;
  logic           w_ovf_evt;

  // Stage p0 -> p1: operand B (sign flipped for sub) ordered against the accumulator.
  assign w_a_mag  = r_acc[M-1:0];
  assign w_b_mag  = r_din_p0[M-1:0];
  assign w_b_sign = r_din_p0[N-1] ^ (r_op_p0 == OP_SUB);
  assign w_a_ge   = (w_a_mag >= w_b_mag);

  // Stage p1 -> acc: magnitude add or subtract, then overflow handling and normalisation.
  assign w_sum = r_same_p1 ? ({1'b0, r_big_p1} + {1'b0, r_small_p1})
                           : ({1'b0, r_big_p1} - {1'b0, r_small_p1});

  always_comb begin
    w_acc_nxt = r_acc;
    w_ovf_evt = 1'b0;
    case (r_op_p0)
      OP_ADD, OP_SUB: begin
        w_ovf_evt = w_sum[M];
        w_acc_nxt = norm(r_sign_p1, sat_mag(w_sum));
      end
      OP_LOAD: w_acc_nxt = norm(r_din_p0[N-1], r_din_p0[M-1:0]);
      OP_CLR:  w_acc_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_state    <= op[1] ? S_WRITE : S_CMP;
          end
        end
        S_CMP: r_state <= S_WRITE;
        S_WRITE: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_acc       <= w_acc_nxt;
          r_out_valid <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
      // A new overflow beats a simultaneous clear request.
      if ((r_state == S_WRITE) && w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && in_valid) begin
      r_op_p0  <= op;
      r_din_p0 <= din;
    end
    if (r_state == S_CMP) begin
      r_same_p1 <= (r_acc[N-1] == w_b_sign);
      if (w_a_ge) begin
        r_big_p1   <= w_a_mag;
        r_small_p1 <= w_b_mag;
        r_sign_p1  <= r_acc[N-1];
      end else begin
        r_big_p1   <= w_b_mag;
        r_small_p1 <= w_a_mag;
        r_sign_p1  <= w_b_sign;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign acc       = r_acc;
  assign ovf       = r_ovf;

endmodule

// File: doc/sign_mag_accum.md
Name: sign_mag_accum

Overview:
- Parametrised N-bit sign-magnitude accumulator. It is the sequential successor of the combinational 4-bit sign-magnitude adder.
- Accepts one operand per transaction over a valid/ready handshake. Opcodes: add, subtract, load, clear.
- Holds a registered running result and flags overflow. Overflow either saturates or wraps, selected by parameter.
- Sits between a switch/UART operand source and a display or register-file sink in the prototyping designs.

Parameters:
- N, 8: total word width (bit N-1 = sign, bits N-2..0 = magnitude; M = N-1). N >= 3.
- SAT, 1: 1 = saturate magnitude to 2^M-1 on overflow; 0 = wrap (keep low M bits).

Ports:
- clk  in  1  single system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand/opcode presented
- in_ready  out  1  block can accept a transaction
- op  in  2  00 add, 01 sub, 10 load, 11 clear
- din  in  N  sign-magnitude operand (ignored for clear)
- ovf_clr  in  1  clears sticky overflow flag
- acc  out  N  accumulator, sign-magnitude, registered
- out_valid  out  1  one-cycle pulse when acc has just been updated
- ovf  out  1  sticky overflow flag

Behaviour:
- Clock and reset: one clock (clk). Synchronous active-low reset (reset_n sampled on the rising clk edge).
- Reset: acc=0, ovf=0, out_valid=0, FSM=IDLE, in_ready=1. Reset mid-operation aborts the operation: no acc update, no out_valid.
- Accept: a transaction is accepted on an edge where in_valid & in_ready. op and din are captured on that edge. din is never resampled afterwards.
- FSM states: IDLE, CMP, WRITE. in_ready=1 only in IDLE.
  - IDLE: on accept, add/sub go to CMP; load/clear go to WRITE.
  - CMP: operand B = din with the sign inverted for sub. Compare |acc| vs |B|. Register larger magnitude, smaller magnitude, result sign, and the same-sign flag. Then go to WRITE.
  - WRITE: compute result and update acc and ovf at the exiting edge. Then go to IDLE.
- out_valid: asserted for exactly one cycle, the cycle after the WRITE edge.
- Latency (accept at edge k):
  - add/sub: acc updated at edge k+2.
  - load/clear: acc updated at edge k+1.
  - Throughput: one add/sub per 3 cycles; one load/clear per 2 cycles.
- Same signs: mag = |acc|+|B| (M+1 bits), sign kept.
  - If bit M is set, this is overflow.
  - SAT=1: mag = 2^M-1.
  - SAT=0: mag = low M bits.
- Different signs: mag = larger-smaller, sign of the larger operand. Never overflows.
- Zero normalisation: any zero-magnitude result, load of -0, or clear produces acc = all zeros (+0). -0 never appears on acc.
- Operand -0: treated as +0 in all arithmetic.
- ovf: set on the WRITE edge of an overflowing op; held until ovf_clr or reset.
  - ovf_clr and a new overflow on the same edge: set wins.
  - Load and clear do not touch ovf.
- acc is stable between updates. in_valid while busy is ignored; the source must hold it until in_ready.

Test Plan (N=8):
- Reset: hold reset_n=0 two cycles with in_valid=1 -> acc=0x00, ovf=0, out_valid=0, in_ready=1. After release, first accept proceeds normally.
- Load 0x05 (+5), then add 0x83 (-3):
  - acc=0x05 at k+1.
  - acc=0x02 exactly two edges after add accept.
  - out_valid one cycle each.
  - in_ready=0 during CMP/WRITE.
- From +2, sub 0x05 -> acc=0x83 (-3). Then sub 0x83 -> acc=0x00 (not 0x80).
- Load 0x7E (+126), add 0x05:
  - SAT=1: acc=0x7F, ovf=1.
  - SAT=0: acc=0x03, ovf=1.
  - Assert ovf_clr on the same edge as the next overflow: ovf stays 1. Assert ovf_clr alone: ovf=0.
- Load 0x80 (-0) -> acc=0x00. Clear from 0x85 -> acc=0x00. Add 0x80 to 0x85 -> 0x85.
- Back-to-back: hold in_valid=1 with 3 queued ops -> each applied exactly once, in order.
  - Pull reset_n low during CMP -> acc=0, no out_valid pulse, in_ready=1 next cycle.
